// File: rtl/tcm_pkg.sv
// Shared types and constants for the TCM memory port front-end.
package tcm_pkg;

  localparam logic [31:0] TCM_BYTES   = 32'h0002_0000;
  localparam int          TCM_WORD_AW = 14;
  localparam int          TCM_TAG_W   = 8;

  typedef struct packed {
    logic [31:0]          data;
    logic [TCM_TAG_W-1:0] tag;
    logic                 error;
  } tcm_resp_t;

  // Pick the 32-bit half of a 64-bit RAM word addressed by byte-address bit 2.
  function automatic logic [31:0] tcm_lane_sel(input logic [63:0] word, input logic lane);
    return lane ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/tcm_resp_fifo.sv
// Synchronous FIFO holding completed responses; head is visible combinationally.
module tcm_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full;

  assign full   = (count_o == CW'(DEPTH));
  assign head_o = mem[rd_ptr];

  // Storage is not reset; consumers qualify the head with count_o.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      count_o <= count_o + CW'(push_i) - CW'(pop_i);
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i) assert (!(push_i && full));
  end

endmodule

// File: rtl/tcm_mem_port.sv
// Request/response front-end for one port of the 64-bit TCM RAM.
module tcm_mem_port
  import tcm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RESP_DEPTH = 4,
  parameter int          TAG_W      = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_rd_i,
  input  logic [3:0]             req_wr_i,
  input  logic [31:0]            req_addr_i,
  input  logic [31:0]            req_data_i,
  input  logic [TAG_W-1:0]       req_tag_i,
  output logic                   req_accept_o,
  output logic                   resp_valid_o,
  output logic [31:0]            resp_data_o,
  output logic [TAG_W-1:0]       resp_tag_o,
  output logic                   resp_error_o,
  input  logic                   resp_accept_i,
  output logic [TCM_WORD_AW-1:0] ram_addr_o,
  output logic [63:0]            ram_data_o,
  output logic [7:0]             ram_wr_o,
  input  logic [63:0]            ram_data_i
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int QW = $clog2(RESP_DEPTH) + 1;

  logic [31:0]    off;
  logic           in_range, is_wr, req_present, accept, pop;
  logic [CW-1:0]  cred;

  logic             s1_vld, s1_lane, s1_rd, s1_err;
  logic [TAG_W-1:0] s1_tag;

  tcm_resp_t        push_data, head;
  logic [QW-1:0]    q_count;

  assign off         = req_addr_i - BASE_ADDR;
  assign in_range    = off < TCM_BYTES;
  assign is_wr       = |req_wr_i;
  assign req_present = req_rd_i | is_wr;

  // Credits cover stage 1 plus FIFO occupancy, so the FIFO can never overflow.
  assign req_accept_o = cred < CW'(RESP_DEPTH);
  assign accept       = req_present & req_accept_o;
  assign pop          = resp_valid_o & resp_accept_i;

  assign ram_addr_o = off[TCM_WORD_AW+2:3];
  assign ram_data_o = {2{req_data_i}};
  assign ram_wr_o   = (accept & is_wr & in_range)
                    ? (off[2] ? {req_wr_i, 4'b0000} : {4'b0000, req_wr_i})
                    : 8'h00;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cred <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cred <= cred + 1'b1;
        2'b01:   cred <= cred - 1'b1;
        default: cred <= cred;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld  <= 1'b0;
      s1_tag  <= '0;
      s1_lane <= 1'b0;
      s1_rd   <= 1'b0;
      s1_err  <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_tag  <= req_tag_i;
        s1_lane <= off[2];
        s1_rd   <= !is_wr;
        s1_err  <= !in_range;
      end
    end
  end

  // RAM read data is valid the cycle after the address, aligned with stage 1.
  always_comb begin
    push_data       = '0;
    push_data.data  = (s1_rd & !s1_err) ? tcm_lane_sel(ram_data_i, s1_lane) : 32'h0;
    push_data.tag   = TCM_TAG_W'(s1_tag);
    push_data.error = s1_err;
  end

  tcm_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH ($bits(tcm_resp_t))
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (s1_vld),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (q_count)
  );

  assign resp_valid_o = (q_count != '0);
  assign resp_data_o  = resp_valid_o ? head.data          : 32'h0;
  assign resp_tag_o   = resp_valid_o ? TAG_W'(head.tag)   : '0;
  assign resp_error_o = resp_valid_o ? head.error         : 1'b0;

endmodule

// File: doc/tcm_mem_port.md
# tcm_mem_port

Single-port request/response front-end for one port of the 128 KB dual-port, read-first, 64-bit TCM RAM. Accepts 32-bit byte-strobed read/write requests from the core (instruction or data side), maps them onto the RAM's 64-bit word / 8-bit byte-enable port, and returns in-order tagged responses through a credit-limited response FIFO with backpressure. One instance sits directly upstream of each TCM RAM port.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of TCM offset 0; 128 KB window, 128 KB-aligned.
- RESP_DEPTH, 4: response FIFO entries and max outstanding requests; legal 2..8, power of 2.
- TAG_W, 8: request tag width.
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_rd_i  in  1  read request.
- req_wr_i  in  4  byte-write strobes; nonzero means write request.
- req_addr_i  in  32  byte address; bits [1:0] ignored.
- req_data_i  in  32  write data.
- req_tag_i  in  TAG_W  tag echoed on the response.
- req_accept_o  out  1  request accepted this cycle when high with a request present.
- resp_valid_o  out  1  response available.
- resp_data_o  out  32  read data; 0 for writes and errors.
- resp_tag_o  out  TAG_W  tag of the request.
- resp_error_o  out  1  address outside the TCM window.
- resp_accept_i  in  1  consumer pops the response.
- ram_addr_o  out  14  RAM word address.
- ram_data_o  out  64  RAM write data.
- ram_wr_o  out  8  RAM byte write enables.
- ram_data_i  in  64  RAM registered read data, valid one cycle after address.

## Operation
- Request present = req_rd_i | (req_wr_i != 0). If req_wr_i != 0, the request is a write; req_rd_i is ignored.
- Credit counter `cred` (0..RESP_DEPTH): +1 on accept, −1 on pop (resp_valid_o & resp_accept_i); both in one cycle leaves it unchanged. req_accept_o = (cred < RESP_DEPTH), registered-input only, with no combinational path from resp_accept_i.
- In range = (req_addr_i − BASE_ADDR) < 32'h2_0000 (unsigned, 32-bit wrap). off = req_addr_i − BASE_ADDR.
- ram_addr_o = off[16:3], combinational. It is driven every cycle and don't-care when idle.
- ram_data_o = {req_data_i, req_data_i}.
- ram_wr_o = (accept & write & in-range) ? (off[2] ? {req_wr_i,4'b0} : {4'b0,req_wr_i}) : 8'h00.
- Pipeline stage 1 register, set on accept: valid, tag, lane = off[2], is_read, error = !in_range.
- Stage 1 valid in cycle T+1 pushes {data, tag, error} into the FIFO. data = is_read & !error ? (lane ? ram_data_i[63:32] : ram_data_i[31:0]) : 0.
- The FIFO never overflows because credits bound it. A push into a full FIFO is an assertion failure.
- Responses are strictly in acceptance order.
- resp_* outputs are taken from the FIFO head and held stable while resp_valid_o & !resp_accept_i.

## Timing
- Reset values: req_accept_o 1 (cred = 0), resp_valid_o 0, resp_data_o 0, resp_tag_o 0, resp_error_o 0, ram_wr_o 0, stage 1 invalid, FIFO empty.
- Accept in cycle T, RAM sampled at edge ending T, push at edge ending T+1, resp_valid_o high in T+2. Fixed latency is 2 cycles with an empty FIFO.
- Throughput: one request per cycle sustained when resp_accept_i stays high (credit freed the cycle after pop; RESP_DEPTH 4 ≥ 3 in flight).
- Back-to-back write then read of the same word: the read returns the new data.
- Read-first behaviour applies only to the same-edge write on the other port.
- Reset mid-operation: in-flight and buffered responses are dropped. RAM writes already issued at a prior edge persist.
- Stalled consumer: after RESP_DEPTH accepts with no pops, req_accept_o is 0 until the first pop; it returns to 1 the cycle after.

## Structure
- Package tcm_pkg: TCM_BYTES = 32'h2_0000, TCM_WORD_AW = 14, a lane-select function, and the response struct {data, tag, error}.
- Sub-module tcm_resp_fifo: synchronous FIFO parameterised by depth and width, with push, pop, head outputs and count, reset to empty.

## Test plan
- Write 32'hDEAD_BEEF, strb 4'hF, to BASE+0x4, then read BASE+0x4. Required: ram_wr_o = 8'hF0, ram_addr_o 0, read response data DEAD_BEEF at T+2, tag echoed.
- Byte write strb 4'b0010, data 32'h0000_AB00, to BASE+0x10 over word 0x11223344, then read. Required: data 0x1122AB44.
- Read BASE+0x2_0000 and BASE−4. Required: resp_error_o 1, data 0, ram_wr_o stays 0 for the erroring write.
- Hold resp_accept_i 0 and issue 6 reads. Required: exactly 4 accepted; req_accept_o falls after the 4th. Then pop one per cycle: responses arrive in order, and req_accept_o rises the cycle after the first pop.
- Streaming 16 reads with resp_accept_i = 1. Required: req_accept_o never drops, and 16 ordered responses arrive with 2-cycle latency.
- Assert rst_i with 3 responses buffered. Required: resp_valid_o 0 and req_accept_o 1 immediately after reset release, and no stale responses afterward.
